// File: rtl/csr_regfile.sv
// csr_regfile: LoongArch control/status registers committed from writeback.
// Holds privilege, exception and timer state. Decode reads it combinationally;
// fetch takes the exception and ertn targets from it.
module csr_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] csr_rd_num,
    output logic [31:0] csr_rd_value,
    input  logic        csr_we,
    input  logic [13:0] csr_wr_num,
    input  logic [31:0] csr_wr_mask,
    input  logic [31:0] csr_wr_value,
    input  logic        wb_ex,
    input  logic [5:0]  wb_ecode,
    input  logic [8:0]  wb_esubcode,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_vaddr,
    input  logic        ertn_flush,
    input  logic [7:0]  hw_int_in,
    input  logic        ipi_int_in,
    output logic [31:0] ex_entry,
    output logic [31:0] ertn_entry,
    output logic        has_int
);

    localparam logic [13:0] CSR_CRMD   = 14'h00;
    localparam logic [13:0] CSR_PRMD   = 14'h01;
    localparam logic [13:0] CSR_ECFG   = 14'h04;
    localparam logic [13:0] CSR_ESTAT  = 14'h05;
    localparam logic [13:0] CSR_ERA    = 14'h06;
    localparam logic [13:0] CSR_BADV   = 14'h07;
    localparam logic [13:0] CSR_EENTRY = 14'h0C;
    localparam logic [13:0] CSR_SAVE0  = 14'h30;
    localparam logic [13:0] CSR_SAVE1  = 14'h31;
    localparam logic [13:0] CSR_SAVE2  = 14'h32;
    localparam logic [13:0] CSR_SAVE3  = 14'h33;
    localparam logic [13:0] CSR_TID    = 14'h40;
    localparam logic [13:0] CSR_TCFG   = 14'h41;
    localparam logic [13:0] CSR_TVAL   = 14'h42;
    localparam logic [13:0] CSR_TICLR  = 14'h44;

    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;

    // LIE bit 10 and IS bit 10 do not exist
    localparam logic [12:0] LIE_MASK = 13'h1BFF;

    logic [1:0]  crmd_plv_q, crmd_plv_d;
    logic        crmd_ie_q, crmd_ie_d;
    logic        crmd_da_q, crmd_da_d;
    logic        crmd_pg_q, crmd_pg_d;
    logic [1:0]  prmd_pplv_q, prmd_pplv_d;
    logic        prmd_pie_q, prmd_pie_d;
    logic [12:0] ecfg_lie_q, ecfg_lie_d;
    logic [12:0] estat_is_q, estat_is_d;
    logic [5:0]  estat_ecode_q, estat_ecode_d;
    logic [8:0]  estat_esubcode_q, estat_esubcode_d;
    logic [31:0] era_q, era_d;
    logic [31:0] badv_q, badv_d;
    logic [25:0] eentry_va_q, eentry_va_d;
    logic [31:0] save0_q, save0_d;
    logic [31:0] save1_q, save1_d;
    logic [31:0] save2_q, save2_d;
    logic [31:0] save3_q, save3_d;
    logic [31:0] tid_q, tid_d;
    logic        tcfg_en_q, tcfg_en_d;
    logic        tcfg_periodic_q, tcfg_periodic_d;
    logic [29:0] tcfg_initval_q, tcfg_initval_d;
    logic [31:0] tval_q, tval_d;

    logic [31:0] crmd_rv, prmd_rv, ecfg_rv, estat_rv, tcfg_rv;
    logic        wr_ok;
    logic        tcfg_wr;
    logic [31:0] tcfg_new;
    logic        ticlr_hit;
    logic        timer_fire;

    function automatic logic [31:0] masked_write(input logic [31:0] old_val,
                                                 input logic [31:0] mask,
                                                 input logic [31:0] value);
        return (old_val & ~mask) | (value & mask);
    endfunction

    assign crmd_rv  = {27'b0, crmd_pg_q, crmd_da_q, crmd_ie_q, crmd_plv_q};
    assign prmd_rv  = {29'b0, prmd_pie_q, prmd_pplv_q};
    assign ecfg_rv  = {19'b0, ecfg_lie_q};
    assign estat_rv = {1'b0, estat_esubcode_q, estat_ecode_q, 3'b0, estat_is_q};
    assign tcfg_rv  = {tcfg_initval_q, tcfg_periodic_q, tcfg_en_q};

    // A software write only lands when no exception or ertn commits alongside it
    assign wr_ok     = csr_we & ~wb_ex & ~ertn_flush;
    assign tcfg_wr   = wr_ok && (csr_wr_num == CSR_TCFG);
    assign tcfg_new  = masked_write(tcfg_rv, csr_wr_mask, csr_wr_value);
    assign ticlr_hit = wr_ok && (csr_wr_num == CSR_TICLR) && csr_wr_mask[0] && csr_wr_value[0];

    // Timer countdown: a TCFG write reloads, otherwise count down and fire at 1
    always_comb begin
        tval_d     = tval_q;
        timer_fire = 1'b0;
        if (tcfg_wr) begin
            tval_d = {tcfg_new[31:2], 2'b00};
        end else if (tcfg_en_q && (tval_q != 32'd0)) begin
            if (tval_q == 32'd1) begin
                timer_fire = 1'b1;
                tval_d     = tcfg_periodic_q ? {tcfg_initval_q, 2'b00} : 32'd0;
            end else begin
                tval_d = tval_q - 32'd1;
            end
        end
    end

    // Next-state for all CSRs: exception beats ertn beats software write
    always_comb begin
        crmd_plv_d       = crmd_plv_q;
        crmd_ie_d        = crmd_ie_q;
        crmd_da_d        = crmd_da_q;
        crmd_pg_d        = crmd_pg_q;
        prmd_pplv_d      = prmd_pplv_q;
        prmd_pie_d       = prmd_pie_q;
        ecfg_lie_d       = ecfg_lie_q;
        estat_is_d       = estat_is_q;
        estat_ecode_d    = estat_ecode_q;
        estat_esubcode_d = estat_esubcode_q;
        era_d            = era_q;
        badv_d           = badv_q;
        eentry_va_d      = eentry_va_q;
        save0_d          = save0_q;
        save1_d          = save1_q;
        save2_d          = save2_q;
        save3_d          = save3_q;
        tid_d            = tid_q;
        tcfg_en_d        = tcfg_en_q;
        tcfg_periodic_d  = tcfg_periodic_q;
        tcfg_initval_d   = tcfg_initval_q;

        estat_is_d[9:2] = hw_int_in;
        estat_is_d[10]  = 1'b0;
        estat_is_d[12]  = ipi_int_in;
        if (ticlr_hit) begin
            estat_is_d[11] = 1'b0;
        end else if (timer_fire) begin
            estat_is_d[11] = 1'b1;
        end

        if (wb_ex) begin
            prmd_pplv_d      = crmd_plv_q;
            prmd_pie_d       = crmd_ie_q;
            crmd_plv_d       = 2'b00;
            crmd_ie_d        = 1'b0;
            era_d            = wb_pc;
            estat_ecode_d    = wb_ecode;
            estat_esubcode_d = wb_esubcode;
            if (wb_ecode == ECODE_ADEF) begin
                badv_d = wb_pc;
            end else if (wb_ecode == ECODE_ALE) begin
                badv_d = wb_vaddr;
            end
        end else if (ertn_flush) begin
            crmd_plv_d = prmd_pplv_q;
            crmd_ie_d  = prmd_pie_q;
        end else if (csr_we) begin
            case (csr_wr_num)
                CSR_CRMD: begin
                    crmd_plv_d = masked_write(crmd_rv, csr_wr_mask, csr_wr_value) >> 0;
                    crmd_ie_d  = csr_wr_mask[2] ? csr_wr_value[2] : crmd_ie_q;
                    crmd_da_d  = csr_wr_mask[3] ? csr_wr_value[3] : crmd_da_q;
                    crmd_pg_d  = csr_wr_mask[4] ? csr_wr_value[4] : crmd_pg_q;
                end
                CSR_PRMD: begin
                    prmd_pplv_d = (prmd_pplv_q & ~csr_wr_mask[1:0]) | (csr_wr_value[1:0] & csr_wr_mask[1:0]);
                    prmd_pie_d  = csr_wr_mask[2] ? csr_wr_value[2] : prmd_pie_q;
                end
                CSR_ECFG: begin
                    ecfg_lie_d = masked_write(ecfg_rv, csr_wr_mask, csr_wr_value) >> 0 & LIE_MASK;
                end
                CSR_ESTAT: begin
                    estat_is_d[1:0] = (estat_is_q[1:0] & ~csr_wr_mask[1:0]) | (csr_wr_value[1:0] & csr_wr_mask[1:0]);
                end
                CSR_ERA:    era_d   = masked_write(era_q, csr_wr_mask, csr_wr_value);
                CSR_BADV:   badv_d  = masked_write(badv_q, csr_wr_mask, csr_wr_value);
                CSR_EENTRY: eentry_va_d = masked_write({eentry_va_q, 6'b0}, csr_wr_mask, csr_wr_value) >> 6;
                CSR_SAVE0:  save0_d = masked_write(save0_q, csr_wr_mask, csr_wr_value);
                CSR_SAVE1:  save1_d = masked_write(save1_q, csr_wr_mask, csr_wr_value);
                CSR_SAVE2:  save2_d = masked_write(save2_q, csr_wr_mask, csr_wr_value);
                CSR_SAVE3:  save3_d = masked_write(save3_q, csr_wr_mask, csr_wr_value);
                CSR_TID:    tid_d   = masked_write(tid_q, csr_wr_mask, csr_wr_value);
                CSR_TCFG: begin
                    tcfg_en_d       = tcfg_new[0];
                    tcfg_periodic_d = tcfg_new[1];
                    tcfg_initval_d  = tcfg_new[31:2];
                end
                default: ;
            endcase
        end
    end

    // State register; reset overrides every same-cycle event
    always_ff @(posedge clk) begin
        if (reset) begin
            crmd_plv_q       <= 2'b00;
            crmd_ie_q        <= 1'b0;
            crmd_da_q        <= 1'b1;
            crmd_pg_q        <= 1'b0;
            prmd_pplv_q      <= 2'b00;
            prmd_pie_q       <= 1'b0;
            ecfg_lie_q       <= 13'b0;
            estat_is_q       <= 13'b0;
            estat_ecode_q    <= 6'b0;
            estat_esubcode_q <= 9'b0;
            era_q            <= 32'b0;
            badv_q           <= 32'b0;
            eentry_va_q      <= 26'b0;
            save0_q          <= 32'b0;
            save1_q          <= 32'b0;
            save2_q          <= 32'b0;
            save3_q          <= 32'b0;
            tid_q            <= 32'b0;
            tcfg_en_q        <= 1'b0;
            tcfg_periodic_q  <= 1'b0;
            tcfg_initval_q   <= 30'b0;
            tval_q           <= 32'b0;
        end else begin
            crmd_plv_q       <= crmd_plv_d;
            crmd_ie_q        <= crmd_ie_d;
            crmd_da_q        <= crmd_da_d;
            crmd_pg_q        <= crmd_pg_d;
            prmd_pplv_q      <= prmd_pplv_d;
            prmd_pie_q       <= prmd_pie_d;
            ecfg_lie_q       <= ecfg_lie_d;
            estat_is_q       <= estat_is_d;
            estat_ecode_q    <= estat_ecode_d;
            estat_esubcode_q <= estat_esubcode_d;
            era_q            <= era_d;
            badv_q           <= badv_d;
            eentry_va_q      <= eentry_va_d;
            save0_q          <= save0_d;
            save1_q          <= save1_d;
            save2_q          <= save2_d;
            save3_q          <= save3_d;
            tid_q            <= tid_d;
            tcfg_en_q        <= tcfg_en_d;
            tcfg_periodic_q  <= tcfg_periodic_d;
            tcfg_initval_q   <= tcfg_initval_d;
            tval_q           <= tval_d;
        end
    end

    // Decode read port; unimplemented numbers and TICLR read as zero
    always_comb begin
        csr_rd_value = 32'b0;
        case (csr_rd_num)
            CSR_CRMD:   csr_rd_value = crmd_rv;
            CSR_PRMD:   csr_rd_value = prmd_rv;
            CSR_ECFG:   csr_rd_value = ecfg_rv;
            CSR_ESTAT:  csr_rd_value = estat_rv;
            CSR_ERA:    csr_rd_value = era_q;
            CSR_BADV:   csr_rd_value = badv_q;
            CSR_EENTRY: csr_rd_value = {eentry_va_q, 6'b0};
            CSR_SAVE0:  csr_rd_value = save0_q;
            CSR_SAVE1:  csr_rd_value = save1_q;
            CSR_SAVE2:  csr_rd_value = save2_q;
            CSR_SAVE3:  csr_rd_value = save3_q;
            CSR_TID:    csr_rd_value = tid_q;
            CSR_TCFG:   csr_rd_value = tcfg_rv;
            CSR_TVAL:   csr_rd_value = tval_q;
            default:    csr_rd_value = 32'b0;
        endcase
    end

    assign ex_entry   = {eentry_va_q, 6'b0};
    assign ertn_entry = era_q;
    assign has_int    = crmd_ie_q & (|(estat_is_q & ecfg_lie_q));

endmodule

// File: tb/tb_csr_regfile.sv
// tb_csr_regfile: directed checks of csr_regfile with hand-computed expectations.
module tb_csr_regfile;

    logic        clk;
    logic        reset;
    logic [13:0] csr_rd_num;
    logic [31:0] csr_rd_value;
    logic        csr_we;
    logic [13:0] csr_wr_num;
    logic [31:0] csr_wr_mask;
    logic [31:0] csr_wr_value;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc;
    logic [31:0] wb_vaddr;
    logic        ertn_flush;
    logic [7:0]  hw_int_in;
    logic        ipi_int_in;
    logic [31:0] ex_entry;
    logic [31:0] ertn_entry;
    logic        has_int;

    int checks;
    int failures;

    csr_regfile dut (
        .clk          (clk),
        .reset        (reset),
        .csr_rd_num   (csr_rd_num),
        .csr_rd_value (csr_rd_value),
        .csr_we       (csr_we),
        .csr_wr_num   (csr_wr_num),
        .csr_wr_mask  (csr_wr_mask),
        .csr_wr_value (csr_wr_value),
        .wb_ex        (wb_ex),
        .wb_ecode     (wb_ecode),
        .wb_esubcode  (wb_esubcode),
        .wb_pc        (wb_pc),
        .wb_vaddr     (wb_vaddr),
        .ertn_flush   (ertn_flush),
        .hw_int_in    (hw_int_in),
        .ipi_int_in   (ipi_int_in),
        .ex_entry     (ex_entry),
        .ertn_entry   (ertn_entry),
        .has_int      (has_int)
    );

    // 20-unit clock
    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkCsr(input string tag, input logic [13:0] num, input logic [31:0] expected);
        csr_rd_num = num;
        #1;
        checkOutput(tag, csr_rd_value, expected);
    endtask

    task automatic applyStimulus(input logic [13:0] num, input logic [31:0] mask, input logic [31:0] value);
        csr_we       = 1'b1;
        csr_wr_num   = num;
        csr_wr_mask  = mask;
        csr_wr_value = value;
        tick();
        csr_we       = 1'b0;
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        reset        = 1'b1;
        csr_rd_num   = 14'h0;
        csr_we       = 1'b0;
        csr_wr_num   = 14'h0;
        csr_wr_mask  = 32'h0;
        csr_wr_value = 32'h0;
        wb_ex        = 1'b0;
        wb_ecode     = 6'h0;
        wb_esubcode  = 9'h0;
        wb_pc        = 32'h0;
        wb_vaddr     = 32'h0;
        ertn_flush   = 1'b0;
        hw_int_in    = 8'h0;
        ipi_int_in   = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        $display("[TB] reset values");
        checkCsr("rst_crmd", 14'h00, 32'h0000_0008);
        checkCsr("rst_estat", 14'h05, 32'h0);
        checkCsr("rst_tval", 14'h42, 32'h0);
        checkCsr("rd_unimpl", 14'h99, 32'h0);
        checkOutput("rst_ex_entry", ex_entry, 32'h0);
        checkOutput("rst_ertn_entry", ertn_entry, 32'h0);
        checkOutput("rst_has_int", {31'b0, has_int}, 32'h0);

        $display("[TB] masked writes");
        applyStimulus(14'h00, 32'h7, 32'h7);
        checkCsr("crmd_wr", 14'h00, 32'h0000_000F);
        applyStimulus(14'h05, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checkCsr("estat_wr", 14'h05, 32'h0000_0003);
        applyStimulus(14'h05, 32'h3, 32'h0);
        checkCsr("estat_clr", 14'h05, 32'h0);
        applyStimulus(14'h40, 32'hFFFF_0000, 32'hCAFE_F00D);
        checkCsr("tid_mask", 14'h40, 32'hCAFE_0000);
        applyStimulus(14'h42, 32'hFFFF_FFFF, 32'h1234_5678);
        checkCsr("tval_ro", 14'h42, 32'h0);
        applyStimulus(14'h30, 32'hFFFF_FFFF, 32'hA5A5_0001);
        checkCsr("save0_wr", 14'h30, 32'hA5A5_0001);

        $display("[TB] exception with dropped write");
        wb_ex        = 1'b1;
        wb_ecode     = 6'h0B;
        wb_esubcode  = 9'h0;
        wb_pc        = 32'h1C00_0100;
        wb_vaddr     = 32'hDEAD_BEEF;
        csr_we       = 1'b1;
        csr_wr_num   = 14'h30;
        csr_wr_mask  = 32'hFFFF_FFFF;
        csr_wr_value = 32'h1234_5678;
        tick();
        wb_ex  = 1'b0;
        csr_we = 1'b0;
        checkCsr("ex_crmd", 14'h00, 32'h0000_0008);
        checkCsr("ex_prmd", 14'h01, 32'h0000_0007);
        checkCsr("ex_era", 14'h06, 32'h1C00_0100);
        checkCsr("ex_estat", 14'h05, 32'h000B_0000);
        checkCsr("ex_badv_untouched", 14'h07, 32'h0);
        checkCsr("ex_save0_kept", 14'h30, 32'hA5A5_0001);
        checkOutput("ex_ertn_entry", ertn_entry, 32'h1C00_0100);

        ertn_flush = 1'b1;
        tick();
        ertn_flush = 1'b0;
        checkCsr("ertn_crmd", 14'h00, 32'h0000_000F);

        $display("[TB] ADEF and ALE badv");
        wb_ex    = 1'b1;
        wb_ecode = 6'h08;
        wb_pc    = 32'h1C00_0200;
        wb_vaddr = 32'h1111_1110;
        tick();
        checkCsr("adef_badv", 14'h07, 32'h1C00_0200);
        wb_ecode    = 6'h09;
        wb_esubcode = 9'h001;
        wb_pc       = 32'h1C00_0300;
        wb_vaddr    = 32'h0000_1003;
        tick();
        wb_ex = 1'b0;
        checkCsr("ale_badv", 14'h07, 32'h0000_1003);
        checkCsr("ale_estat", 14'h05, 32'h0049_0000);
        checkCsr("ale_prmd", 14'h01, 32'h0);

        ertn_flush   = 1'b1;
        csr_we       = 1'b1;
        csr_wr_num   = 14'h31;
        csr_wr_mask  = 32'hFFFF_FFFF;
        csr_wr_value = 32'h7777_7777;
        tick();
        ertn_flush = 1'b0;
        csr_we     = 1'b0;
        checkCsr("ertn_save1_kept", 14'h31, 32'h0);
        checkCsr("ertn_crmd2", 14'h00, 32'h0000_0008);

        applyStimulus(14'h0C, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checkOutput("ex_entry", ex_entry, 32'hFFFF_FFC0);
        checkCsr("eentry_rd", 14'h0C, 32'hFFFF_FFC0);
        applyStimulus(14'h00, 32'h7, 32'h4);
        checkCsr("crmd_ie", 14'h00, 32'h0000_000C);

        $display("[TB] periodic timer");
        applyStimulus(14'h04, 32'hFFFF_FFFF, 32'h0000_0800);
        checkCsr("ecfg_lie11", 14'h04, 32'h0000_0800);
        applyStimulus(14'h41, 32'hFFFF_FFFF, 32'h0000_000B);
        checkCsr("tcfg_rd", 14'h41, 32'h0000_000B);
        checkCsr("tval_load", 14'h42, 32'h8);
        for (int i = 1; i <= 7; i++) begin
            tick();
            checkCsr("tval_count", 14'h42, 32'(8 - i));
        end
        checkOutput("pre_fire_int", {31'b0, has_int}, 32'h0);
        tick();
        checkCsr("tval_reload", 14'h42, 32'h8);
        checkCsr("fire_estat", 14'h05, 32'h0049_0800);
        checkOutput("fire_int", {31'b0, has_int}, 32'h1);
        applyStimulus(14'h44, 32'hFFFF_FFFF, 32'h1);
        checkOutput("ticlr_int", {31'b0, has_int}, 32'h0);
        checkCsr("ticlr_estat", 14'h05, 32'h0049_0000);
        checkCsr("ticlr_rd", 14'h44, 32'h0);

        $display("[TB] one-shot timer");
        applyStimulus(14'h41, 32'hFFFF_FFFF, 32'h0000_0005);
        checkCsr("os_load", 14'h42, 32'h4);
        for (int i = 1; i <= 3; i++) begin
            tick();
            checkCsr("os_count", 14'h42, 32'(4 - i));
        end
        tick();
        checkCsr("os_zero", 14'h42, 32'h0);
        checkOutput("os_int", {31'b0, has_int}, 32'h1);
        applyStimulus(14'h44, 32'h1, 32'h1);
        tick();
        tick();
        checkCsr("os_stays_zero", 14'h42, 32'h0);
        checkCsr("os_fires_once", 14'h05, 32'h0049_0000);

        $display("[TB] expiry coincident with clear");
        applyStimulus(14'h41, 32'hFFFF_FFFF, 32'h0000_0005);
        tick();
        tick();
        tick();
        checkCsr("co_tval1", 14'h42, 32'h1);
        applyStimulus(14'h44, 32'h1, 32'h1);
        checkCsr("co_estat", 14'h05, 32'h0049_0000);
        checkOutput("co_int", {31'b0, has_int}, 32'h0);
        checkCsr("co_tval0", 14'h42, 32'h0);

        $display("[TB] hardware interrupt");
        applyStimulus(14'h04, 32'hFFFF_FFFF, 32'h0000_0004);
        checkOutput("hw_pre", {31'b0, has_int}, 32'h0);
        hw_int_in = 8'h01;
        #1;
        checkOutput("hw_no_bypass", {31'b0, has_int}, 32'h0);
        tick();
        checkOutput("hw_int", {31'b0, has_int}, 32'h1);
        checkCsr("hw_estat", 14'h05, 32'h0049_0004);

        $display("[TB] reset mid-count");
        applyStimulus(14'h41, 32'hFFFF_FFFF, 32'h0000_000B);
        tick();
        tick();
        checkCsr("mid_tval", 14'h42, 32'h6);
        reset    = 1'b1;
        wb_ex    = 1'b1;
        wb_ecode = 6'h08;
        wb_pc    = 32'h0000_0055;
        tick();
        reset     = 1'b0;
        wb_ex     = 1'b0;
        hw_int_in = 8'h00;
        checkCsr("r2_crmd", 14'h00, 32'h0000_0008);
        checkCsr("r2_estat", 14'h05, 32'h0);
        checkCsr("r2_tcfg", 14'h41, 32'h0);
        checkCsr("r2_ecfg", 14'h04, 32'h0);
        checkCsr("r2_badv", 14'h07, 32'h0);
        checkOutput("r2_has_int", {31'b0, has_int}, 32'h0);
        checkOutput("r2_ex_entry", ex_entry, 32'h0);
        checkOutput("r2_ertn_entry", ertn_entry, 32'h0);
        tick();
        checkCsr("r2_tval_frozen", 14'h42, 32'h0);
        checkCsr("r2_save0", 14'h30, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/csr_regfile.md
# csr_regfile

Control/status register file for the LoongArch pipeline, sitting directly downstream of the writeback stage. It commits CSR writes issued by `csrwr`/`csrxchg`, records exception state on a WB-raised exception, and restores privilege state on `ertn`. It runs the stable timer, collects interrupt sources and supplies the fetch stage with the exception entry and return targets. The decode stage reads CSRs combinationally.

## Interface
- Parameters: none.

Ports:
- `clk` in 1: clock, all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `csr_rd_num` in 14: CSR number read by decode.
- `csr_rd_value` out 32: combinational read data; 0 for any unimplemented number.
- `csr_we` in 1: commit a CSR write; already qualified by WB valid.
- `csr_wr_num` in 14: CSR number being written.
- `csr_wr_mask` in 32: per-bit write mask.
- `csr_wr_value` in 32: write data.
- `wb_ex` in 1: exception committed in WB this cycle.
- `wb_ecode` in 6: exception code.
- `wb_esubcode` in 9: exception subcode.
- `wb_pc` in 32: PC of the excepting instruction.
- `wb_vaddr` in 32: faulting address, used for ADEF/ALE only.
- `ertn_flush` in 1: `ertn` committed in WB this cycle.
- `hw_int_in` in 8: hardware interrupt levels.
- `ipi_int_in` in 1: inter-processor interrupt level.
- `ex_entry` out 32: EENTRY value, the fetch target on exception.
- `ertn_entry` out 32: ERA value, the fetch target on `ertn`.
- `has_int` out 1: an interrupt is pending and enabled.

## Operation
- Implemented CSRs and writable fields:
  - CRMD 0x00: PLV[1:0], IE[2], DA[3], PG[4]; other bits 0.
  - PRMD 0x01: PPLV[1:0], PIE[2].
  - ECFG 0x04: LIE[9:0], LIE[12:11].
  - ESTAT 0x05: IS[1:0] writable; IS[9:2], IS[11], IS[12] hardware-owned; Ecode[21:16] and EsubCode[30:22] hardware-owned.
  - ERA 0x06: all bits.
  - BADV 0x07: all bits.
  - EENTRY 0x0C: VA[31:6]; bits [5:0] read 0.
  - SAVE0–3 0x30–0x33: all bits.
  - TID 0x40: all bits.
  - TCFG 0x41: En[0], Periodic[1], InitVal[31:2].
  - TVAL 0x42: read-only.
  - TICLR 0x44: write-1 to bit 0 clears the timer interrupt; always reads 0.
- Masked write: new = (old & ~mask) | (value & mask). Only writable bits listed above change. Writes to read-only or unimplemented CSRs are ignored.
- On `wb_ex`:
  - PRMD.PPLV←CRMD.PLV, PRMD.PIE←CRMD.IE.
  - CRMD.PLV←0, CRMD.IE←0.
  - ERA←`wb_pc`.
  - ESTAT.Ecode/EsubCode←inputs.
  - BADV←`wb_vaddr` only when Ecode is 0x08 (ADEF) or 0x09 (ALE); when ADEF, BADV←`wb_pc` instead.
- On `ertn_flush`: CRMD.PLV←PRMD.PPLV, CRMD.IE←PRMD.PIE.
- Same-cycle priority: `wb_ex` > `ertn_flush` > `csr_we`. A `csr_we` in a cycle with `wb_ex` or `ertn_flush` is dropped entirely, for every CSR.
- ESTAT.IS[9:2] is sampled from `hw_int_in` every cycle. IS[12] is sampled from `ipi_int_in` every cycle.
- Timer:
  - A write to TCFG loads TVAL←{new InitVal, 2'b00} on the same edge.
  - Otherwise, when En=1 and TVAL≠0, TVAL decrements by 1 each cycle.
  - When En=1 and TVAL==1: set IS[11]. Next TVAL = {InitVal,2'b00} if Periodic, else 0 (timer stops).
  - En=0 freezes TVAL.
  - Timer set and TICLR clear in the same cycle: clear wins.
- `has_int` = CRMD.IE & |(ESTAT.IS[12:0] & ECFG.LIE[12:0]).
- `ex_entry` = {EENTRY[31:6], 6'b0}; `ertn_entry` = ERA.

## Timing
- Every register update, including timer and interrupt sampling, lands on the rising edge. All outputs are combinational from registers.
- A write or exception is therefore visible on `csr_rd_value`, `ex_entry`, `ertn_entry` and `has_int` one cycle after it is presented. No same-cycle bypass: decode must interlock on an in-flight CSR write.
- `hw_int_in` to `has_int`: 1 cycle.
- Reset, applied at any time including mid-count or during `wb_ex`:
  - CRMD=0x0000_0008 (DA=1, PLV=0, IE=0).
  - All other CSRs and TVAL = 0; timer disabled.
  - `has_int`=0, `ex_entry`=0, `ertn_entry`=0.
  - Reset overrides every same-cycle event.

## Test plan
- Reset, then read 0x00/0x05/0x42 → 0x8 / 0x0 / 0x0. Read 0x99 → 0.
- Write CRMD, mask 0x7, value 0x7 → CRMD=0xF. Write ESTAT, mask 0xFFFF_FFFF, value 0xFFFF_FFFF → only IS[1:0] set, ESTAT=0x3.
- CRMD PLV=3, IE=1; `wb_ex` with ecode 0x0B, pc 0x1C00_0100 → next cycle: CRMD PLV=0/IE=0, PRMD=0x7, ERA=0x1C00_0100, ESTAT[21:16]=0x0B. Same-cycle `csr_we` to SAVE0 → SAVE0 unchanged. Then `ertn_flush` → CRMD PLV=3, IE=1.
- TCFG ← 0x0000_000B (InitVal=2, Periodic, En) → TVAL=8, reaches 1 after 7 cycles. IS[11] set on the next edge and TVAL reloads 8. With ECFG.LIE[11]=1, IE=1 → `has_int`=1. Write TICLR=1 → IS[11]=0, `has_int`=0.
- One-shot TCFG ← 0x5 → TVAL counts 4→0 and stays 0, IS[11] set once. Timer expiry coincident with a TICLR write → IS[11] stays 0.
- `hw_int_in`=0x01, LIE[2]=1, IE=1 → `has_int`=1 one cycle later. Assert `reset` mid-count → all CSRs back to reset values, `has_int`=0.
